// File: rtl/camera_frame_capture.sv
// rtl/camera_frame_capture.sv - captures one RGB565 camera frame into the frame RAM
//
// Oversamples the OV7670-style byte bus in the system clock domain and writes
// each accepted byte to the frame RAM write port. Reports the byte count of
// the last completed frame and pulses o_done when the frame ends.
//
// Parameters:
//   MAX_BYTES        RAM capacity in bytes; bytes beyond it are dropped
//   ADDR_W           address / byte-count width, 2^ADDR_W >= MAX_BYTES
// Ports:
//   i_clk, i_rst     system clock, asynchronous active-high reset
//   i_start          capture request, sampled only while idle
//   i_pclk, i_vsync, i_href, i_data   camera bus (sampled as data)
//   o_RAM_adress, o_RAM_data, o_RAM_we   frame RAM write port
//   o_BytesPerFrame  bytes written in the last completed frame
//   o_done           one-cycle pulse at frame end
//   o_busy           high whenever not idle
//   o_overflow       sticky, a byte was dropped for lack of RAM
// Optional feature:
//   CAPTURE_DECIMATE_EN  horizontal decimation by 2 (keeps pixels 0, 2, 4, ...)

module camera_frame_capture #(
    parameter int MAX_BYTES = 19200,
    parameter int ADDR_W    = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pclk,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_data,
    output logic [ADDR_W-1:0] o_RAM_adress,
    output logic [7:0]        o_RAM_data,
    output logic              o_RAM_we,
    output logic [ADDR_W-1:0] o_BytesPerFrame,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_overflow
);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    // One extra bit so the saturated address can equal MAX_BYTES even when
    // MAX_BYTES == 2^ADDR_W.
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_BYTES);

    state_t state, state_next;

    // [0],[1] form the synchroniser; [2] is the previous synchronised value
    // used for edge detection.
    logic [2:0] pclk_sr;
    logic [2:0] vsync_sr;
    logic [1:0] href_sr;
    // Data runs through the same three stages as pclk so the byte taken on
    // a detected rising edge is the one that was on the bus at that edge.
    logic [7:0] data_d1, data_d2, data_d3;

    logic [ADDR_W:0] addr, addr_next;
    logic            pe, vf, vr, href_s;
    logic            accept, keep, wr, drop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pclk_sr  <= '0;
            vsync_sr <= '0;
            href_sr  <= '0;
            data_d1  <= '0;
            data_d2  <= '0;
            data_d3  <= '0;
        end else begin
            pclk_sr  <= {pclk_sr[1:0], i_pclk};
            vsync_sr <= {vsync_sr[1:0], i_vsync};
            href_sr  <= {href_sr[0], i_href};
            data_d1  <= i_data;
            data_d2  <= data_d1;
            data_d3  <= data_d2;
        end
    end

    assign pe     = pclk_sr[1] & ~pclk_sr[2];
    assign vf     = ~vsync_sr[1] & vsync_sr[2];
    assign vr     = vsync_sr[1] & ~vsync_sr[2];
    assign href_s = href_sr[1];

    assign accept = (state == CAPTURE) && pe && href_s;

`ifdef CAPTURE_DECIMATE_EN
    // Counts every byte of the line; bit 1 selects the even pixels
    // (bytes 0,1 kept, 2,3 skipped, ...).
    logic [1:0] line_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            line_cnt <= '0;
        end else if (state == IDLE && i_start) begin
            line_cnt <= '0;
        end else if (!href_s) begin
            line_cnt <= '0;
        end else if (accept) begin
            line_cnt <= line_cnt + 2'd1;
        end
    end

    assign keep = ~line_cnt[1];
`else
    assign keep = 1'b1;
`endif

    assign wr        = accept && keep && (addr < MAX_CNT);
    assign drop      = accept && keep && !(addr < MAX_CNT);
    assign addr_next = wr ? addr + 1'b1 : addr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = WAIT_VS;
            WAIT_VS: if (vf)      state_next = CAPTURE;
            CAPTURE: if (vr)      state_next = DONE;
            DONE:                 state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr            <= '0;
            o_RAM_adress    <= '0;
            o_RAM_data      <= '0;
            o_RAM_we        <= 1'b0;
            o_BytesPerFrame <= '0;
            o_overflow      <= 1'b0;
        end else begin
            o_RAM_we <= 1'b0;
            if (state == IDLE && i_start) begin
                addr       <= '0;
                o_overflow <= 1'b0;
            end else begin
                if (wr) begin
                    o_RAM_we     <= 1'b1;
                    o_RAM_adress <= addr[ADDR_W-1:0];
                    o_RAM_data   <= data_d3;
                end
                if (drop) begin
                    o_overflow <= 1'b1;
                end
                addr <= addr_next;
                // addr_next already includes a byte arriving in the same cycle.
                if (state == CAPTURE && vr) begin
                    o_BytesPerFrame <= addr_next[ADDR_W-1:0];
                end
            end
        end
    end

    assign o_done = (state == DONE);
    assign o_busy = (state != IDLE);

endmodule

// File: doc/camera_frame_capture.md
# camera_frame_capture

Captures one RGB565 frame from the OV7670-style camera byte bus and writes it byte-by-byte into the frame RAM that the colour-recognition stage later reads. It sits directly upstream of that stage. It produces the RAM write port, the valid byte count for the frame (the downstream `i_BytesPerFrame`), and a one-cycle done pulse. All camera inputs are oversampled in the system clock domain, so no second clock exists.

## Interface
- `MAX_BYTES`, default 19200: RAM capacity in bytes; writes beyond it are dropped.
- `ADDR_W`, default 15: address and byte-count width; must satisfy 2^ADDR_W ≥ MAX_BYTES.
- `i_clk` in 1: system clock; all logic on rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_start` in 1: capture request, sampled only in IDLE.
- `i_pclk` in 1: camera pixel clock, treated as data.
- `i_vsync` in 1: camera vsync; high = vertical blanking.
- `i_href` in 1: camera line-valid.
- `i_data` in 8: camera byte.
- `o_RAM_adress` out ADDR_W: write address.
- `o_RAM_data` out 8: write data.
- `o_RAM_we` out 1: write strobe; exactly one cycle per byte.
- `o_BytesPerFrame` out ADDR_W: bytes written in the last completed frame.
- `o_done` out 1: one-cycle pulse at frame end.
- `o_busy` out 1: high in every state except IDLE.
- `o_overflow` out 1: sticky; set if any byte was dropped because of MAX_BYTES.

## Operation
- Input conditioning:
  - `i_pclk`, `i_vsync` and `i_href` each pass through a 2-flop synchroniser.
  - `i_data` is delayed by the same 2 stages plus 1, so the data stays aligned with the detected pclk rising edge.
  - Event `pe` is a synchronised pclk 0→1 transition.
  - Event `vf` is a synchronised vsync falling edge (frame start).
  - Event `vr` is a synchronised vsync rising edge (frame end).
- FSM states: IDLE, WAIT_VS, CAPTURE, DONE.
  - **IDLE**: when `i_start`=1, clear the address, the line byte counter and `o_overflow`, then go to WAIT_VS.
  - **WAIT_VS**: on `vf`, go to CAPTURE. Bytes seen before `vf` are ignored, which rejects a partial frame.
  - **CAPTURE**: on `pe` with href=1, accept the byte.
    - If the address is below MAX_BYTES: write it, then increment the address.
    - Otherwise: set `o_overflow` and do not write.
    - The line byte counter increments on every accepted byte and clears whenever href=0.
    - On `vr`, latch the address into `o_BytesPerFrame` and go to DONE.
  - **DONE**: assert `o_done` for exactly one cycle, then go to IDLE.
- If `pe` and `vr` occur in the same cycle, the byte is processed first and the latched count includes it.
- The address saturates at MAX_BYTES and never wraps.
- `o_RAM_adress` holds its last value while `o_RAM_we`=0.
- A new `i_start` during WAIT_VS, CAPTURE or DONE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, synchronisers 0.
- Reset mid-capture aborts the frame immediately. No done pulse is produced, and `o_BytesPerFrame` returns to 0.
- Latency from an `i_pclk` rise at the pin to `o_RAM_we` is 3 `i_clk` cycles. Address and data are valid in the same cycle as `o_RAM_we`.
- `vr` leads to `o_done` after 1 cycle (the DONE state). `o_BytesPerFrame` is valid in the same cycle `o_done` is high and holds until the next frame completes.
- Requirement: `i_pclk` high and low phases each last at least 2 `i_clk` periods.
- Throughput: at most one byte per 4 `i_clk` cycles.

## Configuration
- `CAPTURE_DECIMATE_EN` defined: horizontal decimation by 2.
  - A byte is accepted only when bit 1 of the line byte counter is 0. This keeps pixels 0, 2, 4, … with both bytes of each kept pixel.
  - The line counter still counts every byte.
- Undefined: every byte is written.

## Test plan
- **Basic frame:** reset, `i_start`, vsync 1→0, 2 lines × 8 bytes (0x00..0x0F), vsync 0→1 → 16 writes at addresses 0..15 with matching data, then `o_done` pulse, `o_BytesPerFrame`=16, `o_overflow`=0.
- **Partial frame rejection:** bytes driven with href=1 before `vf` → no writes; the capture starts at address 0 only after `vf`.
- **Overflow:** MAX_BYTES=10, frame of 16 bytes → writes at addresses 0..9, `o_overflow`=1, `o_BytesPerFrame`=10; a following `i_start` clears `o_overflow`.
- **Async reset mid-capture:** `i_rst` pulse after 5 bytes → outputs 0 immediately, state IDLE, no `o_done`.
- **Decimation (`CAPTURE_DECIMATE_EN`):** 1 line of 8 bytes 0xA0..0xA7 → writes 0xA0, 0xA1, 0xA4, 0xA5, `o_BytesPerFrame`=4.
- **Edge coincidence:** `pe` (href=1) and `vr` in the same cycle at byte 4 → byte written, `o_BytesPerFrame`=5.
